// File: rtl/openmips_div_pkg.sv
// ---------------------------------------------------------------------------
// openmips_div_pkg
//   Shared constants and types for the OpenMIPS iterative divider. The EX
//   stage and the divider both use these, so the two sides agree on the
//   encodings.
//   Contents:
//     DIV_WIDTH                 default operand width
//     div_state_e               FSM state encoding (2 bits)
//     DIV_RESULT_READY/NOT_READY ready_o levels
//     DIV_START/DIV_STOP        start_i levels
//     div_accept()              start request qualified by annul
// ---------------------------------------------------------------------------
package openmips_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // A request is only taken when it is not being flushed in the same cycle.
  function automatic logic div_accept(input logic start, input logic annul);
    logic ok;
    if ((start == DIV_START) && (annul == 1'b0)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/openmips_div_if.sv
// ---------------------------------------------------------------------------
// openmips_div_if
//   Request/response bundle between the EX stage (master) and the divider
//   (slave).
//   Signals:
//     signed_div_i  1        1 = DIV, 0 = DIVU
//     opdata1_i     WIDTH    dividend
//     opdata2_i     WIDTH    divisor
//     start_i       1        request, held until the result is consumed
//     annul_i       1        flush of an in-flight divide
//     result_o      2*WIDTH  {remainder, quotient}
//     ready_o       1        result_o valid
// ---------------------------------------------------------------------------
interface openmips_div_if
  import openmips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/openmips_div_step.sv
// ---------------------------------------------------------------------------
// openmips_div_step
//   One restoring-division step (purely combinational).
//   Ports:
//     i_partial   WIDTH+1  partial remainder shifted left with the next
//                          dividend bit appended
//     i_divisor   WIDTH    divisor magnitude
//     o_next_rem  WIDTH    partial remainder after the trial subtract
//     o_q_bit     1        quotient bit produced by this step
// ---------------------------------------------------------------------------
module openmips_div_step
  import openmips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_partial,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_next_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_diff;

  // Trial subtract in WIDTH+1 bits: a clear sign bit means the divisor fits.
  // The partial remainder is always below twice the divisor, so a successful
  // difference always fits back into WIDTH bits.
  always_comb begin
    w_diff = i_partial - {1'b0, i_divisor};
    if (w_diff[WIDTH] == 1'b0) begin
      o_q_bit    = 1'b1;
      o_next_rem = w_diff[WIDTH-1:0];
    end else begin
      o_q_bit    = 1'b0;
      o_next_rem = i_partial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/openmips_div.sv
// ---------------------------------------------------------------------------
// openmips_div
//   Iterative restoring 32/32 divider for the OpenMIPS EX stage. One quotient
//   bit per clock; DIV and DIVU; divide-by-zero returns zero immediately;
//   annul_i cancels a divide in progress.
//   Ports:
//     clk      single clock, rising edge
//     rst      synchronous active-low reset
//     div_bus  openmips_div_if.slave (operands, start/annul, result/ready)
//   Result layout: result_o = {remainder, quotient} -> {HI, LO}.
//   Timing: accept at edge 0, ready_o after edge WIDTH+1; by-zero after
//   edge 1. The result is held in END until start_i drops.
// ---------------------------------------------------------------------------
module openmips_div
  import openmips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  openmips_div_if.slave div_bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // State and datapath registers.
  div_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_rem;      // partial remainder
  logic [WIDTH-1:0]       r_quo;      // dividend bits out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0]       r_divisor;
  logic                   r_sign_a;
  logic                   r_sign_b;
  logic                   r_signed;
  logic [2*WIDTH-1:0]     r_result;
  logic                   r_ready;

  // Next-state values.
  div_state_e             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic [WIDTH-1:0]       w_divisor_nxt;
  logic                   w_sign_a_nxt;
  logic                   w_sign_b_nxt;
  logic                   w_signed_nxt;
  logic [2*WIDTH-1:0]     w_result_nxt;
  logic                   w_ready_nxt;

  // Combinational helpers.
  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic [WIDTH-1:0]       w_step_rem;
  logic                   w_step_q;
  logic [WIDTH-1:0]       w_quo_fix;
  logic [WIDTH-1:0]       w_rem_fix;
  logic                   w_accept;

  assign w_accept = div_accept(div_bus.start_i, div_bus.annul_i);

  // Operand magnitudes; two's-complement negation only applies to DIV.
  always_comb begin
    if ((div_bus.signed_div_i == 1'b1) && (div_bus.opdata1_i[WIDTH-1] == 1'b1)) begin
      w_abs_a = (~div_bus.opdata1_i) + WIDTH'(1);
    end else begin
      w_abs_a = div_bus.opdata1_i;
    end
    if ((div_bus.signed_div_i == 1'b1) && (div_bus.opdata2_i[WIDTH-1] == 1'b1)) begin
      w_abs_b = (~div_bus.opdata2_i) + WIDTH'(1);
    end else begin
      w_abs_b = div_bus.opdata2_i;
    end
  end

  openmips_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_partial  ({r_rem, r_quo[WIDTH-1]}),
    .i_divisor  (r_divisor),
    .o_next_rem (w_step_rem),
    .o_q_bit    (w_step_q)
  );

  // Sign fixup of the unsigned result. Negation is modulo 2^WIDTH, so
  // most-negative / -1 wraps back to most-negative without any trap.
  always_comb begin
    if ((r_signed == 1'b1) && ((r_sign_a ^ r_sign_b) == 1'b1)) begin
      w_quo_fix = (~r_quo) + WIDTH'(1);
    end else begin
      w_quo_fix = r_quo;
    end
    if ((r_signed == 1'b1) && (r_sign_a == 1'b1)) begin
      w_rem_fix = (~r_rem) + WIDTH'(1);
    end else begin
      w_rem_fix = r_rem;
    end
  end

  // FSM next-state and datapath/output next values; everything holds by default.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divisor_nxt = r_divisor;
    w_sign_a_nxt  = r_sign_a;
    w_sign_b_nxt  = r_sign_b;
    w_signed_nxt  = r_signed;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    case (r_state)
      DIV_FREE: begin
        w_result_nxt = {(2*WIDTH){1'b0}};
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        if (w_accept == 1'b1) begin
          if (div_bus.opdata2_i == {WIDTH{1'b0}}) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            // Operands are captured here only; later input changes are ignored.
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = {CNT_W{1'b0}};
            w_rem_nxt     = {WIDTH{1'b0}};
            w_quo_nxt     = w_abs_a;
            w_divisor_nxt = w_abs_b;
            w_signed_nxt  = div_bus.signed_div_i;
            w_sign_a_nxt  = div_bus.opdata1_i[WIDTH-1];
            w_sign_b_nxt  = div_bus.opdata2_i[WIDTH-1];
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end

      DIV_BY_ZERO: begin
        w_state_nxt  = DIV_END;
        w_result_nxt = {(2*WIDTH){1'b0}};
        w_ready_nxt  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (div_bus.annul_i == 1'b1) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = {(2*WIDTH){1'b0}};
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (r_cnt < CNT_W'(WIDTH)) begin
          w_rem_nxt = w_step_rem;
          w_quo_nxt = {r_quo[WIDTH-2:0], w_step_q};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt  = DIV_END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        if (div_bus.start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = {(2*WIDTH){1'b0}};
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          w_state_nxt = DIV_END;
        end
      end

      default: begin
        w_state_nxt  = DIV_FREE;
        w_result_nxt = {(2*WIDTH){1'b0}};
        w_ready_nxt  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State, datapath and output registers; reset wins over any in-flight divide.
  always_ff @(posedge clk) begin
    if (rst == 1'b0) begin
      r_state   <= DIV_FREE;
      r_cnt     <= {CNT_W{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_quo     <= {WIDTH{1'b0}};
      r_divisor <= {WIDTH{1'b0}};
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_signed  <= 1'b0;
      r_result  <= {(2*WIDTH){1'b0}};
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divisor <= w_divisor_nxt;
      r_sign_a  <= w_sign_a_nxt;
      r_sign_b  <= w_sign_b_nxt;
      r_signed  <= w_signed_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign div_bus.result_o = r_result;
  assign div_bus.ready_o  = r_ready;

endmodule
